// File: rtl/wb_master_if.sv
// Command/response handshake plus Wishbone master bus for wb_master.
// The master modport is the controller side; slave is the requester/bus side.
interface wb_master_if #(
    parameter int unsigned ADR_W = 16
);
    localparam int unsigned DAT_W = 16;
    localparam int unsigned SEL_W = 2;

    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [ADR_W-1:0] cmd_adr_i;
    logic [DAT_W-1:0] cmd_dat_i;
    logic [SEL_W-1:0] cmd_sel_i;

    logic             rsp_valid_o;
    logic [DAT_W-1:0] rsp_dat_o;
    logic             rsp_err_o;

    logic [ADR_W-1:0] wb_adr_o;
    logic [DAT_W-1:0] wb_dat_o;
    logic [DAT_W-1:0] wb_dat_i;
    logic [SEL_W-1:0] wb_sel_o;
    logic             wb_we_o;
    logic             wb_stb_o;
    logic             wb_cyc_o;
    logic             wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_master.sv
// Single-command Wishbone master: accepts one command, runs one bus cycle with
// a bounded ack wait, then returns a one-cycle response strobe.
module wb_master #(
    parameter int unsigned ADR_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    wb_master_if.master bus
);
    localparam int unsigned DAT_W = 16;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ready_q,     ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [DAT_W-1:0] rsp_dat_q,   rsp_dat_d;
    logic [ADR_W-1:0] adr_q,       adr_d;
    logic [DAT_W-1:0] dat_q,       dat_d;
    logic [SEL_W-1:0] sel_q,       sel_d;
    logic             we_q,        we_d;
    logic             cyc_q,       cyc_d;

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
        end
    end

    // Next-state and next-output logic; every output is the registered _d value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                cyc_d   = 1'b0;
                // Accept only when ready is already visible to the requester.
                if (bus.cmd_valid_i && ready_q) begin
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    sel_d   = bus.cmd_sel_i;
                    we_d    = bus.cmd_we_i;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack has priority over a timeout firing in the same cycle.
                if (bus.wb_ack_i) begin
                    rsp_dat_d   = we_q ? DAT_W'(0) : bus.wb_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b0;
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready_o = ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;

endmodule

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 Parameter ADR_W, default 16, width of command and Wishbone address.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles the bus phase waits for wb_ack_i (legal 1..65535).
REQ-003 wb_clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 wb_rst_ni  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 cmd_valid_i  input  1  command request.
REQ-006 cmd_ready_o  output  1  command accepted when cmd_valid_i & cmd_ready_o at a clock edge.
REQ-007 cmd_we_i  input  1  1 = write, 0 = read.
REQ-008 cmd_adr_i  input  ADR_W  target address.
REQ-009 cmd_dat_i  input  16  write data.
REQ-010 cmd_sel_i  input  2  byte selects.
REQ-011 rsp_valid_o  output  1  one-cycle response strobe.
REQ-012 rsp_dat_o  output  16  read data; valid with rsp_valid_o.
REQ-013 rsp_err_o  output  1  timeout flag; valid with rsp_valid_o.
REQ-014 wb_adr_o  output  ADR_W  Wishbone address.
REQ-015 wb_dat_o  output  16  Wishbone write data.
REQ-016 wb_dat_i  input  16  Wishbone read data.
REQ-017 wb_sel_o  output  2  Wishbone byte selects.
REQ-018 wb_we_o  output  1  Wishbone write enable.
REQ-019 wb_stb_o  output  1  Wishbone strobe.
REQ-020 wb_cyc_o  output  1  Wishbone cycle.
REQ-021 wb_ack_i  input  1  Wishbone acknowledge; may assert combinationally in the same cycle as wb_stb_o (zero-wait slave).

Function
REQ-022 FSM states IDLE, BUS, RESP; all outputs registered.
REQ-023 IDLE: cmd_ready_o = 1, wb_cyc_o = wb_stb_o = 0; on accept, latch we/adr/dat/sel into wb_we_o/wb_adr_o/wb_dat_o/wb_sel_o, clear timeout counter, go BUS.
REQ-024 BUS: cmd_ready_o = 0, wb_cyc_o = wb_stb_o = 1; wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o held stable for the whole phase.
REQ-025 BUS with wb_ack_i = 1: capture rsp_dat_o = wb_dat_i for reads, 16'h0000 for writes; rsp_err_o = 0; drop cyc/stb; go RESP.
REQ-026 BUS without ack: counter increments; when counter = TIMEOUT-1 and no ack, rsp_dat_o = 0, rsp_err_o = 1, drop cyc/stb, go RESP; BUS never exceeds TIMEOUT cycles.
REQ-027 Ack in the same cycle the timeout would fire: ack wins, rsp_err_o = 0.
REQ-028 RESP: rsp_valid_o = 1 for exactly one cycle, cyc/stb = 0, cmd_ready_o = 0; next state IDLE.
REQ-029 Latency with zero-wait slave: accept at edge N, cyc/stb high cycle N..N+1, rsp_valid_o high cycle N+1..N+2, cmd_ready_o high again after edge N+2 (one command per 3 cycles).
REQ-030 wb_ack_i outside BUS is ignored; cmd_valid_i outside IDLE is ignored (command held by requester, not dropped).
REQ-031 rsp_dat_o and rsp_err_o hold their last values until the next response.
REQ-032 Timeout counter is 16 bits, saturates never (bounded by REQ-026).

Reset
REQ-033 wb_rst_ni = 0 at an edge: state IDLE; cmd_ready_o = 1 after reset release edge (0 during reset); rsp_valid_o, rsp_err_o, wb_cyc_o, wb_stb_o, wb_we_o = 0; rsp_dat_o, wb_adr_o, wb_dat_o, wb_sel_o = 0; counter = 0.
REQ-034 Reset mid-transaction (BUS or RESP) aborts it: cyc/stb low at the next edge, no response issued.

Verification
REQ-035 Write to zero-wait slave: cmd we=1 adr=1 dat=16'h00A5 sel=2'b11 -> one BUS cycle with wb_dat_o=16'h00A5, rsp_valid_o one cycle later, rsp_err_o=0, rsp_dat_o=16'h0000; slave register reads 8'hA5.
REQ-036 Read from zero-wait slave with switches 8'h3C at adr 0 -> rsp_dat_o = 16'h003C two cycles after accept, rsp_err_o=0.
REQ-037 Slave acks after 5 wait cycles -> cyc/stb high 6 cycles, address/data stable throughout, correct rsp_dat_o.
REQ-038 No ack, TIMEOUT=4 -> cyc/stb high exactly 4 cycles, rsp_valid_o with rsp_err_o=1, rsp_dat_o=0; ack on 4th cycle instead -> rsp_err_o=0.
REQ-039 cmd_valid_i held high continuously for 3 commands -> accepted at 3-cycle spacing, responses in order, no command lost or duplicated.
REQ-040 Reset asserted during BUS -> cyc/stb low next edge, no rsp_valid_o, all outputs at REQ-033 values; next command after release completes normally.
